// File: rtl/uart_word_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_word_loader: packs a length-prefixed little-endian UART byte stream  |
// | into 32-bit instruction-memory writes. Option: UART_WORD_LOADER_CHECKSUM_EN|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_word_loader #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_LEN   = 3'd1;
  localparam logic [2:0] c_S_DATA  = 3'd2;
  localparam logic [2:0] c_S_WRITE = 3'd3;
  localparam logic [2:0] c_S_CHECK = 3'd4;
  localparam logic [2:0] c_S_DONE  = 3'd5;
  localparam logic [2:0] c_S_ERROR = 3'd6;

  // Largest image that still fits between BASE_ADDR and the top of memory.
  localparam logic [32:0] c_LIMIT    = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);
  localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_shift;
  logic [31:0]           r_len;
  logic [31:0]           r_word_idx;
  logic [31:0]           r_timer;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;

  logic [31:0]           w_word;
  logic                  w_last;
  logic                  w_timeout;
  logic                  w_shift_en;
  logic                  w_counting;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_word     = {in_data, r_shift};
  assign w_last     = (r_word_idx + 32'd1) == r_len;
  assign w_timeout  = !in_valid && (r_timer == c_TMO_LAST);
  assign w_addr     = ADDR_WIDTH'(BASE_ADDR) + r_word_idx[ADDR_WIDTH-1:0];
  assign w_counting = (r_state == c_S_LEN) || (r_state == c_S_DATA) || (r_state == c_S_CHECK);
  // A byte landing in the final WRITE belongs to the checksum, not a new word.
  assign w_shift_en = enable && in_valid &&
                      ((r_state == c_S_IDLE) || (r_state == c_S_LEN) || (r_state == c_S_DATA) ||
                       ((r_state == c_S_WRITE) && !w_last));

`ifdef UART_WORD_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       w_csum_ok;
  assign w_csum_ok = (in_data == r_csum);
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_state <= c_S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: if (in_valid) w_next = c_S_LEN;
      c_S_LEN: begin
        if (in_valid && (r_byte_cnt == 2'd3)) begin
          if (w_word == 32'd0)                w_next = c_S_DONE;
          else if ({1'b0, w_word} > c_LIMIT)  w_next = c_S_ERROR;
          else                                w_next = c_S_DATA;
        end else if (w_timeout) begin
          w_next = c_S_ERROR;
        end
      end
      c_S_DATA: begin
        if (in_valid && (r_byte_cnt == 2'd3)) w_next = c_S_WRITE;
        else if (w_timeout)                   w_next = c_S_ERROR;
      end
      c_S_WRITE: begin
        if (!w_last) begin
          w_next = c_S_DATA;
        end else begin
`ifdef UART_WORD_LOADER_CHECKSUM_EN
          if (in_valid) w_next = w_csum_ok ? c_S_DONE : c_S_ERROR;
          else          w_next = c_S_CHECK;
`else
          w_next = c_S_DONE;
`endif
        end
      end
`ifdef UART_WORD_LOADER_CHECKSUM_EN
      c_S_CHECK: begin
        if (in_valid)       w_next = w_csum_ok ? c_S_DONE : c_S_ERROR;
        else if (w_timeout) w_next = c_S_ERROR;
      end
`endif
      c_S_DONE:  w_next = c_S_DONE;
      c_S_ERROR: w_next = c_S_ERROR;
      default:   w_next = c_S_IDLE;
    endcase
    if (!enable) w_next = c_S_IDLE;
  end

  always_comb begin
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    case (r_state)
      c_S_LEN, c_S_DATA, c_S_CHECK: busy = 1'b1;
      c_S_WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
      c_S_DONE:  done  = 1'b1;
      c_S_ERROR: error = 1'b1;
      default:   busy  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_byte_cnt  <= 2'd0;
      r_shift     <= 24'd0;
      r_len       <= 32'd0;
      r_word_idx  <= 32'd0;
      r_timer     <= 32'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else if (!enable) begin
      r_byte_cnt  <= 2'd0;
      r_shift     <= 24'd0;
      r_len       <= 32'd0;
      r_word_idx  <= 32'd0;
      r_timer     <= 32'd0;
    end else begin
      if ((w_next != r_state) || in_valid) r_timer <= 32'd0;
      else if (w_counting)                 r_timer <= r_timer + 32'd1;

      if (w_shift_en) begin
        r_shift    <= w_word[31:8];
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if ((r_state == c_S_LEN) && in_valid && (r_byte_cnt == 2'd3)) r_len <= w_word;
      // Latch the write here so address/data hold after the WRITE cycle.
      if ((r_state == c_S_DATA) && in_valid && (r_byte_cnt == 2'd3)) begin
        r_mem_wdata <= w_word;
        r_mem_addr  <= w_addr;
      end
      if (r_state == c_S_WRITE) r_word_idx <= r_word_idx + 32'd1;
    end
  end

`ifdef UART_WORD_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      r_csum <= 8'd0;
    end else if (in_valid && (((r_state == c_S_DATA)) ||
                              ((r_state == c_S_WRITE) && !w_last))) begin
      r_csum <= r_csum ^ in_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_word_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_word_loader: directed vectors with a write scoreboard.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_word_loader;

  localparam int AW  = 12;
  localparam int TMO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [AW+31:0] sb_q[$];

  uart_word_loader #(
    .ADDR_WIDTH    (AW),
    .BASE_ADDR     (0),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .in_valid (in_valid),
    .in_data  (in_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w >> (8 * i);
      send(t[7:0]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rearm();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && mem_we === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_write", {20'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [AW+31:0] e;
          e = sb_q.pop_front();
          chk("wr_addr", {20'd0, mem_addr}, {20'd0, e[AW+31:32]});
          chk("wr_data", mem_wdata, e[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    idle(3);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_addr",  {20'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b1; enable = 1'b1;
    @(negedge clk);

    // Two words, fully back-to-back bytes.
    sb_q.push_back({12'd0, 32'h1234_5678});
    sb_q.push_back({12'd1, 32'hDEAD_BEEF});
    send4(32'd2);
    chk("len_busy", {31'd0, busy}, 32'd1);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("w0_we_latency", {31'd0, mem_we}, 32'd1);
    send(8'hEF);
    chk("w0_we_one_cycle", {31'd0, mem_we}, 32'd0);
    send(8'hBE); send(8'hAD); send(8'hDE);
    chk("w1_we_latency", {31'd0, mem_we}, 32'd1);
    chk("w1_not_done_yet", {31'd0, done}, 32'd0);
`ifdef UART_WORD_LOADER_CHECKSUM_EN
    @(negedge clk);
    chk("check_busy", {31'd0, busy}, 32'd1);
    send(8'h2A);
`else
    @(negedge clk);
`endif
    chk("two_word_done", {31'd0, done}, 32'd1);
    chk("two_word_busy", {31'd0, busy}, 32'd0);
    send(8'h55);
    chk("done_holds", {31'd0, done}, 32'd1);
    chk("addr_holds", {20'd0, mem_addr}, 32'd1);
    chk("wdata_holds", mem_wdata, 32'hDEAD_BEEF);
    enable = 1'b0;
    @(negedge clk);
    chk("en_low_clears_done", {31'd0, done}, 32'd0);
    enable = 1'b1;
    @(negedge clk);

    // Zero length.
    send4(32'd0);
    chk("len0_done", {31'd0, done}, 32'd1);
    rearm();

    // Oversize and exact-fit length.
    send4(32'h0000_1001);
    chk("oversize_error", {31'd0, error}, 32'd1);
    chk("oversize_busy", {31'd0, busy}, 32'd0);
    rearm();
    chk("error_cleared", {31'd0, error}, 32'd0);
    send4(32'h0000_1000);
    chk("maxlen_busy", {31'd0, busy}, 32'd1);
    chk("maxlen_no_error", {31'd0, error}, 32'd0);
    rearm();

    // Timeout after partial word.
    send4(32'd1);
    send(8'hAA); send(8'hBB);
    idle(TMO - 1);
    chk("tmo_not_early", {31'd0, error}, 32'd0);
    idle(1);
    chk("tmo_error", {31'd0, error}, 32'd1);
    rearm();
    chk("tmo_recover_err", {31'd0, error}, 32'd0);
    chk("tmo_recover_busy", {31'd0, busy}, 32'd0);
    idle(TMO + 5);
    chk("idle_no_timeout", {31'd0, error}, 32'd0);

    // Gapped bytes just inside the timeout window.
    sb_q.push_back({12'd0, 32'h4433_2211});
    send4(32'd1);
    for (int i = 1; i <= 4; i++) begin
      idle(TMO - 2);
      send(8'(i * 8'h11));
    end
`ifdef UART_WORD_LOADER_CHECKSUM_EN
    @(negedge clk);
    send(8'h44);
`else
    @(negedge clk);
`endif
    chk("gapped_done", {31'd0, done}, 32'd1);
    rearm();

    // Reset mid-transfer discards everything.
    send(8'h03); send(8'h00);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    sb_q.push_back({12'd0, 32'hCAFE_F00D});
    send4(32'd1);
    send4(32'hCAFE_F00D);
`ifdef UART_WORD_LOADER_CHECKSUM_EN
    @(negedge clk);
    send(8'hC9);
`else
    @(negedge clk);
`endif
    chk("after_rst_done", {31'd0, done}, 32'd1);

`ifdef UART_WORD_LOADER_CHECKSUM_EN
    rearm();
    sb_q.push_back({12'd0, 32'h0804_0201});
    send4(32'd1);
    send4(32'h0804_0201);
    @(negedge clk);
    send(8'h0F);
    chk("csum_good_done", {31'd0, done}, 32'd1);
    rearm();
    sb_q.push_back({12'd0, 32'h0804_0201});
    send4(32'd1);
    send4(32'h0804_0201);
    @(negedge clk);
    send(8'h0E);
    chk("csum_bad_error", {31'd0, error}, 32'd1);
    chk("csum_bad_not_done", {31'd0, done}, 32'd0);
`endif

    idle(3);
    chk("sb_all_writes_seen", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
